ip_hdr_checker: RTL and testbench

Per-packet IPv4 header checker in the output-port-lookup stage, downstream of the word-position scheduler. It taps the same `in_data`/`in_wr` stream as the scheduler and uses the scheduler's word strobes to find header fields. For each packet it validates the IPv4 header checksum, computes the decremented TTL and the incrementally updated checksum, and queues one result record for the header-editing logic further down the stage.

---
 rtl/ip_hdr_checker_pkg.sv | 29 ++
 rtl/ip_hdr_checker_if.sv | 36 +++
 rtl/ip_hdr_checker_fallthrough_small_fifo.sv | 48 ++++
 rtl/ip_hdr_checker.sv | 142 ++++++++++++++
 tb/tb_ip_hdr_checker.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_hdr_checker_pkg.sv
// Stage-wide IPv4 header-check constants, FSM states and result-record layout.
package ip_hdr_checker_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL_BASIC = 8'h45;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FOLD,
    ST_PUSH
  } hdr_state_t;

  localparam int REC_W             = 28;
  localparam int REC_CKSUM_NEW_LSB = 0;
  localparam int REC_TTL_NEW_LSB   = 16;
  localparam int REC_TTL_EXP_BIT   = 24;
  localparam int REC_CKSUM_OK_BIT  = 25;
  localparam int REC_HDR_OPTS_BIT  = 26;
  localparam int REC_IS_IPV4_BIT   = 27;

  // One's-complement 16-bit add with end-around carry.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/ip_hdr_checker_if.sv
// Tap stream, scheduler word strobes and result-queue handshake of ip_hdr_checker.
interface ip_hdr_checker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  word_ETHERTYPE;
  logic                  word_IP_TTL;
  logic                  word_IP_CHECKSUM;
  logic                  word_LAST_USEFUL;
  logic                  res_vld;
  logic                  res_rdy;
  logic                  res_is_ipv4;
  logic                  res_hdr_opts;
  logic                  res_cksum_ok;
  logic                  res_ttl_expired;
  logic [7:0]            res_ttl_new;
  logic [15:0]           res_cksum_new;
  logic                  res_drop;

  modport master (
    output in_data, in_ctrl, in_wr, word_ETHERTYPE, word_IP_TTL, word_IP_CHECKSUM,
           word_LAST_USEFUL, res_rdy,
    input  res_vld, res_is_ipv4, res_hdr_opts, res_cksum_ok, res_ttl_expired,
           res_ttl_new, res_cksum_new, res_drop
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, word_ETHERTYPE, word_IP_TTL, word_IP_CHECKSUM,
           word_LAST_USEFUL, res_rdy,
    output res_vld, res_is_ipv4, res_hdr_opts, res_cksum_ok, res_ttl_expired,
           res_ttl_new, res_cksum_new, res_drop
  );
endinterface

// File: rtl/ip_hdr_checker_fallthrough_small_fifo.sv
// First-word-fall-through FIFO holding header-check result records.
module fallthrough_small_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign dout  = mem[rd_ptr];
  // When full, a simultaneous pop frees the head slot that the write lands in.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ip_hdr_checker.sv
// Per-packet IPv4 header checksum / TTL checker feeding a result FIFO.
// Optional statistics counters are enabled with `define IP_HDR_CHK_STATS_EN.
module ip_hdr_checker
  import ip_hdr_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int RES_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef IP_HDR_CHK_STATS_EN
  output logic [15:0] stat_bad_cksum,
  output logic [15:0] stat_ttl_expired,
  output logic [15:0] stat_drop,
`endif
  ip_hdr_checker_if.slave bus
);
  hdr_state_t            state;
  logic [15:0]           ethertype, hc, folded;
  logic [7:0]            ver_ihl, ttl;
  logic [19:0]           acc, quad_sum;
  logic [REC_W-1:0]      rec_q, rec_d, head;
  logic                  res_drop_q, fifo_empty, fifo_full;
  logic                  eth_stb, ttl_stb, ck_stb, last_stb;
  logic                  push, pop, is_ipv4;
  logic [DATA_WIDTH-1:0] d;
  logic [CTRL_WIDTH-1:0] unused_ctrl;

  assign d           = bus.in_data;
  assign unused_ctrl = bus.in_ctrl;
  assign eth_stb     = bus.in_wr && bus.word_ETHERTYPE;
  assign ttl_stb     = bus.in_wr && bus.word_IP_TTL;
  assign ck_stb      = bus.in_wr && bus.word_IP_CHECKSUM;
  assign last_stb    = bus.in_wr && bus.word_LAST_USEFUL;
  assign quad_sum    = 20'(d[63:48]) + 20'(d[47:32]) + 20'(d[31:16]) + 20'(d[15:0]);
  assign push        = (state == ST_PUSH);
  assign pop         = !fifo_empty && bus.res_rdy;

  always_comb begin
    rec_d   = '0;
    is_ipv4 = (ethertype == ETHERTYPE_IPV4);
    folded  = csum_add(acc[15:0], {12'b0, acc[19:16]});
    rec_d[REC_IS_IPV4_BIT]  = is_ipv4;
    rec_d[REC_HDR_OPTS_BIT] = (ver_ihl != IP_VER_IHL_BASIC);
    rec_d[REC_CKSUM_OK_BIT] = is_ipv4 && (ver_ihl == IP_VER_IHL_BASIC) && (folded == 16'hFFFF);
    rec_d[REC_TTL_EXP_BIT]  = (ttl <= 8'd1);
    if (!is_ipv4 || ttl == '0) begin
      rec_d[REC_TTL_NEW_LSB +: 8]    = ttl;
      rec_d[REC_CKSUM_NEW_LSB +: 16] = hc;
    end else begin
      rec_d[REC_TTL_NEW_LSB +: 8]    = ttl - 8'd1;
      rec_d[REC_CKSUM_NEW_LSB +: 16] = csum_add(hc, 16'h0100);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ethertype  <= '0;
      ver_ihl    <= '0;
      ttl        <= '0;
      hc         <= '0;
      acc        <= '0;
      rec_q      <= '0;
      res_drop_q <= 1'b0;
    end else begin
      res_drop_q <= push && fifo_full && !pop;
      case (state)
        // An ETHERTYPE word in ST_ACC restarts accumulation for a new packet.
        ST_IDLE, ST_ACC: begin
          if (eth_stb) begin
            ethertype <= d[31:16];
            ver_ihl   <= d[15:8];
            acc       <= 20'(d[15:0]);
            state     <= ST_ACC;
          end else if (state == ST_ACC) begin
            if (ttl_stb) begin
              acc <= acc + quad_sum;
              ttl <= d[15:8];
            end else if (ck_stb) begin
              acc <= acc + quad_sum;
              hc  <= d[63:48];
            end else if (last_stb) begin
              acc   <= acc + 20'(d[63:48]);
              state <= ST_FOLD;
            end
          end
        end
        ST_FOLD: begin
          rec_q <= rec_d;
          state <= ST_PUSH;
        end
        ST_PUSH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  fallthrough_small_fifo #(
    .WIDTH (REC_W),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (rec_q),
    .wr_en (push),
    .rd_en (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.res_vld         = !fifo_empty;
  assign bus.res_drop        = res_drop_q;
  assign bus.res_is_ipv4     = head[REC_IS_IPV4_BIT];
  assign bus.res_hdr_opts    = head[REC_HDR_OPTS_BIT];
  assign bus.res_cksum_ok    = head[REC_CKSUM_OK_BIT];
  assign bus.res_ttl_expired = head[REC_TTL_EXP_BIT];
  assign bus.res_ttl_new     = head[REC_TTL_NEW_LSB +: 8];
  assign bus.res_cksum_new   = head[REC_CKSUM_NEW_LSB +: 16];

`ifdef IP_HDR_CHK_STATS_EN
  logic wr_ok;
  assign wr_ok = push && (!fifo_full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bad_cksum   <= '0;
      stat_ttl_expired <= '0;
      stat_drop        <= '0;
    end else begin
      if (wr_ok && !rec_q[REC_CKSUM_OK_BIT] && stat_bad_cksum != '1)
        stat_bad_cksum <= stat_bad_cksum + 16'd1;
      if (wr_ok && rec_q[REC_TTL_EXP_BIT] && stat_ttl_expired != '1)
        stat_ttl_expired <= stat_ttl_expired + 16'd1;
      if (res_drop_q && stat_drop != '1)
        stat_drop <= stat_drop + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ip_hdr_checker.sv
// Randomized self-checking bench for ip_hdr_checker with a header-level reference model.
module tb_ip_hdr_checker;

  typedef struct packed {
    logic        is_ipv4;
    logic        hdr_opts;
    logic        cksum_ok;
    logic        ttl_expired;
    logic [7:0]  ttl_new;
    logic [15:0] cksum_new;
  } rec_t;

  localparam logic [159:0] BASE_HDR = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ip_hdr_checker_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

`ifdef IP_HDR_CHK_STATS_EN
  logic [15:0] stat_bad_cksum, stat_ttl_expired, stat_drop;
  ip_hdr_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .RES_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stat_bad_cksum(stat_bad_cksum),
    .stat_ttl_expired(stat_ttl_expired), .stat_drop(stat_drop), .bus(bus)
  );
`else
  ip_hdr_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .RES_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned drop_seen = 0;
  bit hold_rdy = 1'b1;
  bit rand_rdy = 1'b0;
  rec_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sum of the ten header halfwords, optionally leaving out the checksum field.
  function automatic logic [15:0] ones_sum(input logic [159:0] hdr, input bit skip_hc);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 10; i++)
      if (!(skip_hc && i == 5)) s += 32'(hdr[159-16*i -: 16]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic rec_t model(input logic [15:0] etype, input logic [159:0] hdr);
    rec_t r;
    logic [15:0] hc;
    logic [7:0] ttl;
    int unsigned t;
    hc = hdr[79:64];
    ttl = hdr[95:88];
    r.is_ipv4 = (etype == 16'h0800);
    r.hdr_opts = (hdr[159:152] != 8'h45);
    r.cksum_ok = r.is_ipv4 && !r.hdr_opts && (ones_sum(hdr, 1'b0) == 16'hFFFF);
    r.ttl_expired = (ttl <= 8'd1);
    if (!r.is_ipv4 || ttl == 8'd0) begin
      r.ttl_new = ttl;
      r.cksum_new = hc;
    end else begin
      r.ttl_new = ttl - 8'd1;
      t = 32'(hc) + 32'h100;
      if (t > 32'hFFFF) t = t - 32'hFFFF;
      r.cksum_new = t[15:0];
    end
    return r;
  endfunction

  function automatic logic [159:0] make_hdr(input logic [7:0] vi, input logic [7:0] ttl, input bit good);
    logic [159:0] h;
    h = {vi, 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), ttl, 8'($urandom),
         16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    if (good) h[79:64] = ~ones_sum(h, 1'b1);
    return h;
  endfunction

  function automatic rec_t dut_head();
    return {bus.res_is_ipv4, bus.res_hdr_opts, bus.res_cksum_ok, bus.res_ttl_expired,
            bus.res_ttl_new, bus.res_cksum_new};
  endfunction

  task automatic drive(input logic wr, input logic [63:0] dat, input logic [3:0] stb);
    @(posedge clk); #1;
    bus.in_wr = wr;
    bus.in_data = dat;
    bus.in_ctrl = 8'($urandom);
    {bus.word_ETHERTYPE, bus.word_IP_TTL, bus.word_IP_CHECKSUM, bus.word_LAST_USEFUL} = stb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, {$urandom, $urandom}, 4'b0000);
  endtask

  // Leading MAC word, then the first nwords strobed header words; bubbles carry a strobe without in_wr.
  task automatic send_words(input logic [15:0] etype, input logic [159:0] hdr, input int nwords);
    logic [63:0] w [4];
    w[0] = {32'($urandom), etype, hdr[159:144]};
    w[1] = hdr[143:80];
    w[2] = hdr[79:16];
    w[3] = {hdr[15:0], 16'($urandom), 32'($urandom)};
    drive(1'b1, {$urandom, $urandom}, 4'b0000);
    for (int k = 0; k < nwords; k++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, {$urandom, $urandom}, 4'b1000 >> k);
      drive(1'b1, w[k], 4'b1000 >> k);
    end
  endtask

  task automatic send_pkt(input logic [15:0] etype, input logic [159:0] hdr, input bit keep, input int gap);
    send_words(etype, hdr, 4);
    if (keep) exp_q.push_back(model(etype, hdr));
    idle(gap);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.res_vld); i++) idle(1);
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic run_directed(input string tag, input logic [15:0] etype, input logic [159:0] hdr, input rec_t e);
    hold_rdy = 1'b1;
    idle(2);
    send_pkt(etype, hdr, 1'b1, 5);
    check_eq({tag, "_vld"}, bus.res_vld, 1);
    check_eq(tag, dut_head(), e);
    hold_rdy = 1'b0;
    wait_drain();
  endtask

  initial begin
    bus.res_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.res_rdy = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (bus.res_drop) drop_seen++;
    if (bus.res_vld && bus.res_rdy) begin
      check_eq("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("sb_record", dut_head(), exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] h;
    logic [15:0] et;
    logic [7:0] vi, ttl;
    int unsigned d0;
    bus.in_wr = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    {bus.word_ETHERTYPE, bus.word_IP_TTL, bus.word_IP_CHECKSUM, bus.word_LAST_USEFUL} = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vld", bus.res_vld, 0);
    check_eq("rst_drop", bus.res_drop, 0);
    check_eq("rst_head", dut_head(), 0);
    reset = 1'b0;
    idle(2);

    // Latency: LAST_USEFUL in cycle N, res_vld first seen in N+3.
    send_words(16'h0800, BASE_HDR, 4);
    exp_q.push_back(model(16'h0800, BASE_HDR));
    idle(1);
    check_eq("lat_n1", bus.res_vld, 0);
    idle(1);
    check_eq("lat_n2", bus.res_vld, 0);
    idle(1);
    check_eq("lat_n3", bus.res_vld, 1);
    check_eq("base_rec", dut_head(), rec_t'({1'b1, 1'b0, 1'b1, 1'b0, 8'h3F, 16'hB961}));
    hold_rdy = 1'b0;
    wait_drain();

    h = BASE_HDR; h[79:64] = 16'hb862;
    run_directed("bad_hc", 16'h0800, h, rec_t'({1'b1, 1'b0, 1'b0, 1'b0, 8'h3F, 16'hB962}));
    h = BASE_HDR; h[95:88] = 8'h01; h[79:64] = 16'hF761;
    run_directed("ttl01", 16'h0800, h, rec_t'({1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 16'hF861}));
    h = BASE_HDR; h[95:88] = 8'h00; h[79:64] = 16'hF861;
    run_directed("ttl00", 16'h0800, h, rec_t'({1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 16'hF861}));
    run_directed("arp", 16'h0806, BASE_HDR, rec_t'({1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 16'hB861}));
    h = BASE_HDR; h[159:152] = 8'h46;
    run_directed("opts", 16'h0800, h, rec_t'({1'b1, 1'b1, 1'b0, 1'b0, 8'h3F, 16'hB961}));

    // Five packets into a depth-4 FIFO with no consumer: the fifth is dropped.
    hold_rdy = 1'b1;
    idle(2);
    d0 = drop_seen;
    for (int i = 0; i < 5; i++)
      send_pkt(16'h0800, make_hdr(8'h45, 8'($urandom_range(2, 255)), 1'b1), i < 4, 5);
    idle(2);
    check_eq("fill_drop", drop_seen - d0, 1);
    check_eq("fill_vld", bus.res_vld, 1);
    hold_rdy = 1'b0;
    wait_drain();

    // Reset between TTL and CHECKSUM words; the trailing words must not complete a packet.
    send_words(16'h0800, BASE_HDR, 2);
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, BASE_HDR[79:16], 4'b0010);
    drive(1'b1, {BASE_HDR[15:0], 48'h0}, 4'b0001);
    idle(6);
    check_eq("rst_mid_no_result", bus.res_vld, 0);
    run_directed("post_rst", 16'h0800, BASE_HDR, rec_t'({1'b1, 1'b0, 1'b1, 1'b0, 8'h3F, 16'hB961}));

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      et = ($urandom_range(0, 9) < 7) ? 16'h0800 : (($urandom_range(0, 1) != 0) ? 16'h0806 : 16'h86DD);
      vi = ($urandom_range(0, 4) != 0) ? 8'h45 : 8'h46;
      case ($urandom_range(0, 4))
        0: ttl = 8'h00;
        1: ttl = 8'h01;
        2: ttl = 8'h02;
        3: ttl = 8'hFF;
        default: ttl = 8'($urandom);
      endcase
      h = make_hdr(vi, ttl, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) send_words(16'h0800, make_hdr(8'h45, 8'h40, 1'b1), 2);
      send_pkt(et, h, 1'b1, 4 + $urandom_range(0, 3));
    end
    wait_drain();
    check_eq("drop_total", drop_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
